lcd_power_sequencer: RTL and testbench

- Sequences the TFT LCD timing generator and panel power rails: VDD enable, timing start, blanking/standby and backlight, in panel-datasheet order.
- Sits between the top-level display-enable control and the LCD timing generator; drives that generator's begin/disable inputs and watches its X/Y pixel counters to count frames.
- Provides a ready flag and a per-frame tick for the pixel/fractal pipeline.

---
 rtl/lcd_power_sequencer.sv | 166 ++++++++++++++++
 tb/tb_lcd_power_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_power_sequencer.sv
// Panel power / timing-generator bring-up and shutdown sequencer.
// Counts frames off the generator's pixel counters to pace the backlight.
module lcd_power_sequencer #(
  parameter int T_PWR_ON        = 1000,
  parameter int T_PWR_OFF       = 1000,
  parameter int N_BL_ON         = 2,
  parameter int N_BL_OFF        = 2,
  parameter int X_COUNTER_WIDTH = 11,
  parameter int Y_COUNTER_WIDTH = 9,
  parameter int DLY_WIDTH       = 16
) (
  input  logic                       i_CLK,
  input  logic                       i_RSTn,
  input  logic                       i_Enable,
  input  logic [X_COUNTER_WIDTH-1:0] i_XPx,
  input  logic [Y_COUNTER_WIDTH-1:0] i_YPx,
  output logic                       o_PowerEn,
  output logic                       o_Begin,
  output logic                       o_Disable,
  output logic                       o_Backlight,
  output logic                       o_Ready,
  output logic                       o_FrameTick,
  output logic [2:0]                 o_State
);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_PWR_WAIT = 3'd1,
    S_START    = 3'd2,
    S_WARMUP   = 3'd3,
    S_ON       = 3'd4,
    S_BL_OFF   = 3'd5,
    S_DIS_WAIT = 3'd6
  } state_t;

  localparam logic [DLY_WIDTH-1:0] LD_ON =
    DLY_WIDTH'(T_PWR_ON > 0 ? T_PWR_ON - 1 : 0);
  localparam logic [DLY_WIDTH-1:0] LD_OFF =
    DLY_WIDTH'(T_PWR_OFF > 0 ? T_PWR_OFF - 1 : 0);
  localparam logic [DLY_WIDTH-1:0] LD_BL_ON  = DLY_WIDTH'(N_BL_ON);
  localparam logic [DLY_WIDTH-1:0] LD_BL_OFF = DLY_WIDTH'(N_BL_OFF);
  localparam logic [DLY_WIDTH-1:0] ONE       = DLY_WIDTH'(1);

  state_t               state_q, state_d;
  logic [DLY_WIDTH-1:0] cnt_q, cnt_d;
  logic [DLY_WIDTH-1:0] cnt_tick;
  logic                 pwr_q, pwr_d;
  logic                 begin_q, begin_d;
  logic                 dis_q, dis_d;
  logic                 bl_q, bl_d;
  logic                 rdy_q, rdy_d;
  logic                 tick_q, tick_d;
  logic                 prev_q, prev_d;
  logic                 origin;

  assign origin = (i_XPx == '0) && (i_YPx == '0);

  // Frame-paced count; checking the post-decrement value lets the
  // transition fire on the tick itself rather than one cycle later.
  assign cnt_tick = (tick_q && cnt_q != '0) ? cnt_q - ONE : cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = origin;
    tick_d  = origin & ~prev_q;
    unique case (state_q)
      S_OFF: begin
        if (i_Enable) begin
          state_d = S_PWR_WAIT;
          cnt_d   = LD_ON;
        end
      end
      S_PWR_WAIT: begin
        if (!i_Enable) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_START;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_START: begin
        state_d = S_WARMUP;
        cnt_d   = LD_BL_ON;
      end
      S_WARMUP: begin
        if (!i_Enable) begin
          state_d = S_DIS_WAIT;
          cnt_d   = LD_OFF;
        end else if (cnt_tick == '0) begin
          state_d = S_ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_tick;
        end
      end
      S_ON: begin
        if (!i_Enable) begin
          state_d = S_BL_OFF;
          cnt_d   = LD_BL_OFF;
        end
      end
      S_BL_OFF: begin
        if (cnt_tick == '0) begin
          state_d = S_DIS_WAIT;
          cnt_d   = LD_OFF;
        end else begin
          cnt_d = cnt_tick;
        end
      end
      S_DIS_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_OFF;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = S_OFF;
        cnt_d   = '0;
      end
    endcase

    // Outputs follow the next state so they change with the transition.
    pwr_d   = (state_d != S_OFF);
    dis_d   = !(state_d inside {S_START, S_WARMUP, S_ON, S_BL_OFF});
    bl_d    = (state_d == S_ON);
    rdy_d   = (state_d == S_ON);
    begin_d = begin_q | (state_d == S_START);
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      pwr_q   <= 1'b0;
      begin_q <= 1'b0;
      dis_q   <= 1'b1;
      bl_q    <= 1'b0;
      rdy_q   <= 1'b0;
      tick_q  <= 1'b0;
      prev_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwr_q   <= pwr_d;
      begin_q <= begin_d;
      dis_q   <= dis_d;
      bl_q    <= bl_d;
      rdy_q   <= rdy_d;
      tick_q  <= tick_d;
      prev_q  <= prev_d;
    end
  end

  assign o_PowerEn   = pwr_q;
  assign o_Begin     = begin_q;
  assign o_Disable   = dis_q;
  assign o_Backlight = bl_q;
  assign o_Ready     = rdy_q;
  assign o_FrameTick = tick_q;
  assign o_State     = state_q;

endmodule

// File: tb/tb_lcd_power_sequencer.sv
// Bench for lcd_power_sequencer with a 10x4 model timing generator.
// Expected timings are queued at stimulus time and popped on observation.
module tb_lcd_power_sequencer;

  localparam int T_ON  = 4;
  localparam int T_OFF = 3;
  localparam int N_ON  = 2;
  localparam int N_OFF = 1;
  localparam int FW    = 10;
  localparam int FH    = 4;
  localparam int FRAME = FW * FH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [10:0] xpx;
  logic [8:0]  ypx;
  logic        o_PowerEn, o_Begin, o_Disable;
  logic        o_Backlight, o_Ready, o_FrameTick;
  logic [2:0]  o_State;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  lcd_power_sequencer #(
    .T_PWR_ON (T_ON),
    .T_PWR_OFF(T_OFF),
    .N_BL_ON  (N_ON),
    .N_BL_OFF (N_OFF)
  ) dut (
    .i_CLK      (clk),
    .i_RSTn     (rst_n),
    .i_Enable   (en),
    .i_XPx      (xpx),
    .i_YPx      (ypx),
    .o_PowerEn  (o_PowerEn),
    .o_Begin    (o_Begin),
    .o_Disable  (o_Disable),
    .o_Backlight(o_Backlight),
    .o_Ready    (o_Ready),
    .o_FrameTick(o_FrameTick),
    .o_State    (o_State)
  );

  always #5 clk = ~clk;

  // Model generator: idle at origin until started, then free-running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xpx <= '0;
      ypx <= '0;
    end else if (o_Begin) begin
      if (xpx == 11'(FW - 1)) begin
        xpx <= '0;
        ypx <= (ypx == 9'(FH - 1)) ? '0 : ypx + 9'd1;
      end else begin
        xpx <= xpx + 11'd1;
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input int obs);
    exp_t e;
    e = sb_q.pop_front();
    chk(e.tag, obs, e.val);
  endtask

  function automatic int vec();
    return int'({o_PowerEn, o_Begin, o_Disable, o_Backlight,
                 o_Ready, o_FrameTick, o_State});
  endfunction

  function automatic int mk(input int pe, input int bg, input int ds,
                            input int bl, input int rd, input int tk,
                            input int st);
    return (pe << 8) | (bg << 7) | (ds << 6) | (bl << 5) |
           (rd << 4) | (tk << 3) | st;
  endfunction

  task automatic wait_state(input logic [2:0] s, input int max,
                            output int n);
    bit hit;
    hit = 1'b0;
    n = -1;
    for (int i = 1; i <= max && !hit; i++) begin
      @(negedge clk);
      if (o_State == s) begin
        n = i;
        hit = 1'b1;
      end
    end
  endtask

  task automatic wait_tick(input int max, output int n);
    bit hit;
    hit = 1'b0;
    n = -1;
    for (int i = 1; i <= max && !hit; i++) begin
      @(negedge clk);
      if (o_FrameTick) begin
        n = i;
        hit = 1'b1;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ticks;
    int rst_vec;
    rst_vec = mk(0, 0, 1, 0, 0, 0, 0);

    #2 rst_n = 1'b0;
    #1 chk("reset_vec", vec(), rst_vec);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle with enable low: nothing moves, no ticks.
    sb_push("idle_ticks", 0);
    ticks = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_FrameTick) ticks++;
    end
    sb_pop(ticks);
    chk("idle_vec", vec(), rst_vec);

    // Power-up.
    sb_push("pe_cycles", T_ON);
    en = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_Begin) break;
      if (o_PowerEn) n++;
    end
    sb_pop(n);
    chk("start_vec", vec(), mk(1, 1, 0, 0, 0, 0, 2));
    wait_state(3'd3, 5, n);
    chk("warmup_entry", n, 1);
    sb_push("tick1", FRAME);
    wait_tick(100, n);
    sb_pop(n);
    sb_push("tick2", FRAME);
    wait_tick(100, n);
    sb_pop(n);
    chk("tick2_vec", vec(), mk(1, 1, 0, 0, 0, 1, 3));
    @(negedge clk);
    chk("on_vec", vec(), mk(1, 1, 0, 1, 1, 0, 4));

    // Orderly shutdown from ON.
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("bloff_vec", vec(), mk(1, 1, 0, 0, 0, 0, 5));
    wait_tick(100, n);
    sb_push("dis_after_tick", 1);
    wait_state(3'd6, 5, n);
    sb_pop(n);
    chk("dis_vec", vec(), mk(1, 1, 1, 0, 0, 0, 6));
    sb_push("pe_off_cycles", T_OFF);
    wait_state(3'd0, 10, n);
    sb_pop(n);
    chk("off_vec", vec(), mk(0, 1, 1, 0, 0, 0, 0));

    // Abort during PWR_WAIT after a fresh reset.
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pwr_wait_vec", vec(), mk(1, 0, 1, 0, 0, 0, 1));
    en = 1'b0;
    @(negedge clk);
    chk("abort_vec", vec(), rst_vec);

    // Full power-up, then re-enable while in BL_OFF.
    @(negedge clk);
    sb_push("on_latency", T_ON + 2 + N_ON * FRAME + 1);
    en = 1'b1;
    wait_state(3'd4, 300, n);
    sb_pop(n);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("bloff_state", int'(o_State), 5);
    @(negedge clk);
    en = 1'b1;
    wait_state(3'd0, 100, n);
    chk("reoff_vec", vec() & ~8, mk(0, 1, 1, 0, 0, 0, 0));
    @(negedge clk);
    chk("repwr_vec", vec() & ~8, mk(1, 1, 1, 0, 0, 0, 1));
    wait_state(3'd3, 20, n);
    wait_tick(60, n);
    chk("first_tick_in_frame", int'(n > 0 && n <= FRAME), 1);

    // Asynchronous reset mid-WARMUP.
    repeat (3) @(negedge clk);
    chk("warmup_state", int'(o_State), 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_vec", vec(), rst_vec);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
